// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM state encoding,
// grant-owner encoding and the grant decision used in IDLE.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_owner_e;

    // MEM stage wins unless fetch has been passed over too many times in a row.
    function automatic gnt_owner_e pick_owner(input logic d_req,
                                              input logic i_req,
                                              input logic starved);
        gnt_owner_e owner;
        if (d_req && !(i_req && starved)) begin
            owner = GNT_D;
        end else begin
            owner = GNT_I;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and unified-memory port of the arbiter.
// slave is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              i_stall;

    logic              d_ren;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_stall;

    logic              bus_err;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem_din;
    logic              mem_ack;

    modport slave (
        input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, mem_din, mem_ack,
        output i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall, bus_err,
               mem_cs, mem_we, mem_addr, mem_dout
    );

    modport master (
        output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, mem_din, mem_ack,
        input  i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall, bus_err,
               mem_cs, mem_we, mem_addr, mem_dout
    );
endinterface

// File: rtl/mem_port_arbiter_arb_watchdog.sv
// Busy-cycle counter for the memory arbiter; expired is high once the
// counter has reached TIMEOUT-1 cycles since the last clear.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int              CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic [CNT_W-1:0] tmo_cnt_d;

    // Next count: clear wins, saturate at LAST so the counter never wraps.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (clr) begin
            tmo_cnt_d = '0;
        end else if (en && (tmo_cnt_q != LAST)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign expired = (tmo_cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency unified memory between the IF and MEM
// pipeline stages, with fetch starvation protection and a hang watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int              SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    arb_state_e        state_q,    state_d;
    logic              mem_cs_q,   mem_cs_d;
    logic              mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
    logic              i_ack_q,    i_ack_d;
    logic              d_ack_q,    d_ack_d;
    logic              bus_err_q,  bus_err_d;
    logic [DATA_W-1:0] i_rdata_q,  i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic [SC_W-1:0]   starve_q,   starve_d;

    logic       d_req_s;
    logic       wd_clr_s;
    logic       wd_en_s;
    logic       wd_expired_s;
    gnt_owner_e owner_s;

    assign d_req_s = bus.d_ren | bus.d_wen;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

    // Grant decision, transaction tracking and completion/abort handling.
    always_comb begin
        state_d    = state_q;
        mem_cs_d   = mem_cs_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        bus_err_d  = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        starve_d   = starve_q;
        wd_clr_s   = 1'b0;
        wd_en_s    = 1'b0;
        owner_s    = pick_owner(d_req_s, bus.i_req, starve_q == STARVE_LIM);

        case (state_q)
            ST_IDLE: begin
                if (d_req_s || bus.i_req) begin
                    mem_cs_d   = 1'b1;
                    mem_dout_d = bus.d_wdata;
                    wd_clr_s   = 1'b1;
                    if (owner_s == GNT_D) begin
                        mem_addr_d = bus.d_addr;
                        mem_we_d   = bus.d_wen;
                        state_d    = ST_D_BUSY;
                        // Only D grants that bypass a waiting fetch count toward starvation.
                        if (bus.i_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + 1'b1;
                        end else if (bus.i_req) begin
                            starve_d = starve_q;
                        end else begin
                            starve_d = '0;
                        end
                    end else begin
                        mem_addr_d = bus.i_addr;
                        mem_we_d   = 1'b0;
                        state_d    = ST_I_BUSY;
                        starve_d   = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                wd_en_s = 1'b1;
                if (bus.mem_ack || wd_expired_s) begin
                    mem_cs_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = ST_DONE;
                    // A real ack takes priority over an expiry in the same cycle.
                    bus_err_d = ~bus.mem_ack;
                    if (state_q == ST_I_BUSY) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.mem_ack ? bus.mem_din : '0;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!bus.mem_ack) begin
                            d_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            d_rdata_d = bus.mem_din;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_cs_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_cs_q   <= mem_cs_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            bus_err_q  <= bus_err_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            starve_q   <= starve_d;
        end
    end

    assign bus.mem_cs   = mem_cs_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.i_ack    = i_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.i_stall  = bus.i_req & ~i_ack_q;
    assign bus.d_stall  = d_req_s & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a per-cycle agent models the memory
// and both requesters; expected grants and completions are queued up front.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } djob_t;
    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] dout; } gnt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4), .TIMEOUT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] i_job_q[$];
    djob_t       d_job_q[$];
    exp_t        exp_i_q[$];
    exp_t        exp_d_q[$];
    gnt_t        exp_gnt_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int          mem_lat = 4;
    logic        stray_ack = 1'b0;
    logic        i_no_expect = 1'b0;
    int          age = 0;
    int          cyc = 0;
    int          cs_rise_cyc = 0;
    int          last_cs_len = 0;
    int          i_req_cyc = 0;
    int          d_req_cyc = 0;
    int          last_i_ack_cyc = 0;
    int          last_d_ack_cyc = 0;
    logic [31:0] model_d_rdata = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        logic [31:0] r;
        if (a == 32'h0000_0100) r = 32'h2402_000A;
        else                    r = {a[15:0], ~a[15:0]};
        return r;
    endfunction

    function automatic gnt_t mk_gnt(input logic [31:0] a, input logic we, input logic [31:0] d);
        gnt_t g;
        g.addr = a; g.we = we; g.dout = d;
        return g;
    endfunction

    function automatic djob_t mk_djob(input logic [31:0] a, input logic we, input logic [31:0] d);
        djob_t j;
        j.addr = a; j.we = we; j.wdata = d;
        return j;
    endfunction

    // Memory model, requesters and scoreboard, acting 1 time unit after each edge.
    initial begin : agent
        gnt_t        cur;
        exp_t        e;
        djob_t       j;
        logic [31:0] a;
        cur = mk_gnt(32'h0, 1'b0, 32'h0);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.mem_cs === 1'b1) begin
                age++;
                if (age == 1) begin
                    cs_rise_cyc = cyc;
                    if (exp_gnt_q.size() == 0) begin
                        check_eq("gnt_unexp", bus.mem_addr, 32'hFFFF_FFFF);
                        cur = mk_gnt(bus.mem_addr, bus.mem_we, bus.mem_dout);
                    end else begin
                        cur = exp_gnt_q.pop_front();
                        check_eq("gnt_addr", bus.mem_addr, cur.addr);
                        check_eq("gnt_we", 32'(bus.mem_we), 32'(cur.we));
                        if (cur.we) check_eq("gnt_dout", bus.mem_dout, cur.dout);
                    end
                end else begin
                    check_eq("addr_stable", bus.mem_addr, cur.addr);
                end
                if (mem_lat != 0 && age == mem_lat) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_din = mdata(bus.mem_addr);
                end else begin
                    bus.mem_ack = 1'b0;
                    bus.mem_din = 32'hBAD0_BAD0;
                end
            end else begin
                if (age != 0) last_cs_len = age;
                age = 0;
                bus.mem_ack = stray_ack;
                bus.mem_din = 32'h5A5A_5A5A;
            end

            check_eq("i_stall", 32'(bus.i_stall), 32'(bus.i_req & ~bus.i_ack));
            check_eq("d_stall", 32'(bus.d_stall), 32'((bus.d_ren | bus.d_wen) & ~bus.d_ack));

            if (bus.i_ack === 1'b1) begin
                last_i_ack_cyc = cyc;
                if (exp_i_q.size() == 0) begin
                    check_eq("i_ack_unexp", 32'(bus.i_ack), 32'h0);
                end else begin
                    e = exp_i_q.pop_front();
                    check_eq("i_rdata", bus.i_rdata, e.rdata);
                    check_eq("i_err", 32'(bus.bus_err), 32'(e.err));
                end
                bus.i_req = 1'b0;
            end
            if (bus.d_ack === 1'b1) begin
                last_d_ack_cyc = cyc;
                if (exp_d_q.size() == 0) begin
                    check_eq("d_ack_unexp", 32'(bus.d_ack), 32'h0);
                end else begin
                    e = exp_d_q.pop_front();
                    check_eq("d_rdata", bus.d_rdata, e.rdata);
                    check_eq("d_err", 32'(bus.bus_err), 32'(e.err));
                end
                bus.d_ren = 1'b0;
                bus.d_wen = 1'b0;
            end
            if (bus.i_ack !== 1'b1 && bus.d_ack !== 1'b1 && !rst)
                check_eq("err_alone", 32'(bus.bus_err), 32'h0);

            if (!bus.i_req && i_job_q.size() != 0) begin
                a = i_job_q.pop_front();
                bus.i_req  = 1'b1;
                bus.i_addr = a;
                i_req_cyc  = cyc;
                e.err   = (mem_lat == 0);
                e.rdata = e.err ? 32'h0 : mdata(a);
                if (!i_no_expect) exp_i_q.push_back(e);
            end
            if (!bus.d_ren && !bus.d_wen && d_job_q.size() != 0) begin
                j = d_job_q.pop_front();
                bus.d_addr  = j.addr;
                bus.d_wdata = j.wdata;
                bus.d_wen   = j.we;
                bus.d_ren   = ~j.we;
                d_req_cyc   = cyc;
                e.err = (mem_lat == 0);
                if (e.err)      e.rdata = 32'h0;
                else if (j.we)  e.rdata = model_d_rdata;
                else            e.rdata = mdata(j.addr);
                model_d_rdata = e.rdata;
                exp_d_q.push_back(e);
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_i_q.size() != 0 || exp_d_q.size() != 0 || i_job_q.size() != 0 ||
                d_job_q.size() != 0 || bus.i_req || bus.d_ren || bus.d_wen) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_in_time", 32'(n < budget), 32'h1);
        check_eq("gnt_left", 32'(exp_gnt_q.size()), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int n;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_ren = 1'b0; bus.d_wen = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_din = '0; bus.mem_ack = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_mem_cs", 32'(bus.mem_cs), 32'h0);
        check_eq("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst_mem_dout", bus.mem_dout, 32'h0);
        check_eq("rst_acks", {29'h0, bus.i_ack, bus.d_ack, bus.bus_err}, 32'h0);
        check_eq("rst_i_rdata", bus.i_rdata, 32'h0);
        check_eq("rst_d_rdata", bus.d_rdata, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Lone fetch: cs for 4 cycles, ack 5 cycles after the request.
        mem_lat = 4;
        exp_gnt_q.push_back(mk_gnt(32'h100, 1'b0, 32'h0));
        i_job_q.push_back(32'h100);
        wait_drain(50);
        check_eq("f_cs_rise", 32'(cs_rise_cyc - i_req_cyc), 32'd1);
        check_eq("f_ack_lat", 32'(last_i_ack_cyc - i_req_cyc), 32'd5);
        check_eq("f_cs_len", 32'(last_cs_len), 32'd4);

        // Collision: load wins, fetch follows.
        mem_lat = 2;
        exp_gnt_q.push_back(mk_gnt(32'h200, 1'b0, 32'h0));
        exp_gnt_q.push_back(mk_gnt(32'h300, 1'b0, 32'h0));
        d_job_q.push_back(mk_djob(32'h200, 1'b0, 32'h0));
        i_job_q.push_back(32'h300);
        wait_drain(50);
        check_eq("coll_gap", 32'((last_i_ack_cyc - last_d_ack_cyc) >= 3), 32'h1);

        // Store leaves d_rdata holding the previous load result.
        exp_gnt_q.push_back(mk_gnt(32'h40, 1'b1, 32'hDEAD_BEEF));
        d_job_q.push_back(mk_djob(32'h40, 1'b1, 32'hDEAD_BEEF));
        wait_drain(50);

        // Starvation: D,D,D,D,I,D,D.
        for (int k = 0; k < 6; k++) begin
            d_job_q.push_back(mk_djob(32'h700 + 32'(k * 4), 1'b1, 32'hC0DE_0000 + 32'(k)));
            if (k == 4) exp_gnt_q.push_back(mk_gnt(32'h600, 1'b0, 32'h0));
            exp_gnt_q.push_back(mk_gnt(32'h700 + 32'(k * 4), 1'b1, 32'hC0DE_0000 + 32'(k)));
        end
        i_job_q.push_back(32'h600);
        wait_drain(200);

        // Timeout: memory never answers a load.
        mem_lat = 0;
        exp_gnt_q.push_back(mk_gnt(32'h80, 1'b0, 32'h0));
        d_job_q.push_back(mk_djob(32'h80, 1'b0, 32'h0));
        wait_drain(50);
        check_eq("t_cs_len", 32'(last_cs_len), 32'd8);
        check_eq("t_ack_lat", 32'(last_d_ack_cyc - d_req_cyc), 32'd9);

        // Reset in I_BUSY, then a stray mem_ack.
        i_no_expect = 1'b1;
        exp_gnt_q.push_back(mk_gnt(32'h500, 1'b0, 32'h0));
        i_job_q.push_back(32'h500);
        n = 0;
        while (bus.mem_cs !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check_eq("r_cs_seen", 32'(bus.mem_cs), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("r_mem_cs", 32'(bus.mem_cs), 32'h0);
        check_eq("r_i_ack", 32'(bus.i_ack), 32'h0);
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("r_idle_cs", 32'(bus.mem_cs), 32'h0);
        i_no_expect = 1'b0;

        // Normal fetch after the reset.
        mem_lat = 3;
        exp_gnt_q.push_back(mk_gnt(32'h104, 1'b0, 32'h0));
        i_job_q.push_back(32'h104);
        wait_drain(50);
        check_eq("p_ack_lat", 32'(last_i_ack_cyc - i_req_cyc), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline.
- Grants the MEM stage by default. A starvation counter guarantees forward progress for fetch.
- Exports per-port stall signals that the pipeline controller ORs into its stage-enable logic.
- A watchdog aborts memory transactions that hang and reports a bus error.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- STARVE_MAX, 4, max consecutive D grants while i_req is pending before I is forced.
- TIMEOUT, 255, cycles in a BUSY state without mem_ack before abort; must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word; valid when i_ack=1
- i_ack  out  1  one-cycle completion pulse for the I port
- i_stall  out  1  i_req & ~i_ack (combinational)
- d_ren  in  1  load request; held until d_ack
- d_wen  in  1  store request; held until d_ack
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse for the D port
- d_stall  out  1  (d_ren|d_wen) & ~d_ack (combinational)
- bus_err  out  1  one-cycle pulse, coincident with the aborted port's ack
- mem_cs  out  1  memory select (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_dout  out  DATA_W  memory write data (registered)
- mem_din  in  DATA_W  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion; sampled only while mem_cs=1

Behaviour:
- Reset values:
  - FSM = IDLE.
  - All mem_* outputs = 0.
  - i_ack, d_ack, bus_err = 0.
  - i_rdata, d_rdata = 0.
  - starve_cnt = 0, tmo_cnt = 0.
- FSM states: IDLE, I_BUSY, D_BUSY, DONE.
- Grant rule in IDLE:
  - d_req = d_ren|d_wen. Grant D if d_req & ~(i_req & starve_cnt==STARVE_MAX); else grant I if i_req; else stay in IDLE.
  - On grant, register mem_cs=1, mem_addr, mem_we (=d_wen for D, 0 for I) and mem_dout (=d_wdata).
  - Move to I_BUSY or D_BUSY and clear tmo_cnt.
- BUSY states:
  - mem_* stay stable and tmo_cnt increments every cycle.
  - On mem_ack=1: capture mem_din into the port's rdata (loads and fetches only; stores leave d_rdata unchanged), pulse that port's ack next cycle, drop mem_cs, go to DONE.
  - On tmo_cnt==TIMEOUT-1 with mem_ack=0: drop mem_cs, go to DONE, pulse that port's ack and bus_err next cycle, force the port's rdata to 0.
- DONE: ack is high for exactly this cycle, then return to IDLE. There is always one dead cycle between transactions, so a requester that holds its request after ack is never double-served from its stale ack.
- Latency:
  - Request seen in IDLE at cycle N → mem_cs high at N+1.
  - mem_ack in cycle M → ack/rdata valid at M+1.
  - Minimum 2 cycles from request to ack; back-to-back transactions every 3 cycles.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on every D grant made while i_req=1.
  - Clears on any I grant, and on any D grant made while i_req=0.
- d_ren & d_wen both high: treated as a store.
- Requester withdrawal: if the request drops mid-transaction (pipeline flush), the memory transaction still completes and the ack still pulses; the requester ignores it.
- rst asserted in any state: next cycle is IDLE with mem_cs=0, and any ack in flight is suppressed.
- Stray mem_ack while mem_cs=0 is ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE/I_BUSY/D_BUSY/DONE, 2 bits) and the grant-owner encoding (GNT_I, GNT_D).
- Optional sub-module arb_watchdog: tmo_cnt with clear, enable and expired output, parameterised by TIMEOUT. The grant logic and FSM stay inline.

Test Plan:
- Lone fetch: i_req=1, i_addr=0x100; memory acks 3 cycles after cs with 0x2402000A → mem_cs high cycles 1-4, i_ack=1 and i_rdata=0x2402000A at cycle 5, i_stall low at cycle 5.
- Collision: i_req and d_ren asserted at the same cycle, d_addr=0x200 → D served first (mem_we=0, addr 0x200), I served next; d_ack precedes i_ack by at least 3 cycles.
- Starvation: i_req held, D issues 6 back-to-back stores with STARVE_MAX=4 → grant order D,D,D,D,I,D,D, and the counter is cleared after the I grant.
- Store: d_wen=1, d_addr=0x40, d_wdata=0xDEADBEEF → mem_we=1, mem_dout=0xDEADBEEF while cs; d_ack pulses; d_rdata unchanged.
- Timeout: d_ren=1 and memory never acks, TIMEOUT=8 → mem_cs drops after 8 cycles; d_ack and bus_err pulse together; d_rdata=0; FSM returns to IDLE.
- Reset mid-transaction: rst during I_BUSY → mem_cs=0 and FSM IDLE next cycle; no i_ack; a later mem_ack pulse is ignored.
